// File: rtl/seg_pkg.sv
// seg_pkg: shared glyphs, constants and state encodings for the seven-segment scanner
package seg_pkg;
    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_DEC = 1'b1;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    typedef enum logic {ST_IDLE, ST_SHIFT} conv_state_t;
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        return SEG_TABLE[h];
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per clock
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);
    // One spare digit above the display width guarantees an overflow field always exists
    localparam int ND = (((BIN_W + 2) / 3 > DIGITS) ? (BIN_W + 2) / 3 : DIGITS) + 1;
    localparam int NW = 4 * ND;
    localparam int CW = $clog2(BIN_W + 1);

    conv_state_t      state_q, state_d;
    logic [NW-1:0]    bcd_q, bcd_d, adj, step;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign busy = state_q == ST_SHIFT;
    assign done = busy && cnt_q == CW'(BIN_W - 1);
    assign step = (adj << 1) | NW'(bin_q[BIN_W-1]);
    assign bcd  = step[4*DIGITS-1:0];
    assign ovf  = |step[NW-1:4*DIGITS];

    // Add-3 correction of every BCD digit of 5 or more before the shift
    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < ND; k++)
            if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end

    // Next state: load on start, then shift one bit per cycle until the last bit
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_SHIFT;
                bcd_d   = '0;
                bin_d   = bin;
                cnt_d   = '0;
            end
        end else begin
            bcd_d   = step;
            bin_d   = bin_q << 1;
            cnt_d   = cnt_q + 1'b1;
            state_d = done ? ST_IDLE : ST_SHIFT;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: N-digit multiplexed hex/decimal seven-segment scanner
// Define SEG_BLINK_EN to add the blink_mask input and its blink-phase counter.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int BIN_W      = 14,
    parameter int SCAN_DIV_W = 16,
    parameter int PWM_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  value_in,
    input  logic              load,
    input  logic              mode,
    input  logic [DIGITS-1:0] dp_in,
    input  logic              blank_lz,
    input  logic [PWM_W-1:0]  brightness,
`ifdef SEG_BLINK_EN
    input  logic [DIGITS-1:0] blink_mask,
`endif
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        display,
    output logic              dp,
    output logic [DIGITS-1:0] digit
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  accept, conv_done, conv_ovf, scan_tick, lz;
    logic [4*DIGITS-1:0]   shadow_q, conv_bcd;
    logic [SCAN_DIV_W-1:0] div_q;
    logic [IW-1:0]         idx_q;
    logic [PWM_W-1:0]      phase;
    logic [3:0]            nib;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [DIGITS-1:0]     digit_d;

    assign accept    = load && !busy;
    assign scan_tick = &div_q;
    assign phase     = div_q[SCAN_DIV_W-1 -: PWM_W];

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
        .clk  (clk),
        .rst  (rst),
        .start(accept && mode == MODE_DEC),
        .bin  (value_in),
        .busy (busy),
        .done (conv_done),
        .bcd  (conv_bcd),
        .ovf  (conv_ovf)
    );

    // Shadow register: hex loads land at once, decimal results only on commit
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q <= '0;
            overflow <= 1'b0;
        end else if (accept && mode == MODE_HEX) begin
            shadow_q <= (4*DIGITS)'(value_in);
            overflow <= 1'b0;
        end else if (conv_done) begin
            shadow_q <= conv_bcd;
            overflow <= conv_ovf;
        end
    end

    // Free-running scan divider; its wrap advances the digit index
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
            if (scan_tick) idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

`ifdef SEG_BLINK_EN
    logic [SCAN_DIV_W+5:0] blink_cnt_q;
    logic                  blink_q;

    // Slow blink phase toggling once per counter wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
            if (&blink_cnt_q) blink_q <= ~blink_q;
        end
    end
`endif

    // Glyph, decimal point and PWM-gated anode for the digit being scanned
    always_comb begin
        nib     = shadow_q[4*idx_q +: 4];
        lz      = blank_lz && idx_q != '0 && (shadow_q >> {idx_q, 2'b00}) == '0;
        seg_d   = overflow ? SEG_DASH : lz ? SEG_BLANK : hex_to_seg(nib);
        dp_d    = overflow | ~dp_in[idx_q];
`ifdef SEG_BLINK_EN
        if (blink_q && blink_mask[idx_q]) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
`endif
        digit_d = (phase <= brightness) ? ~(DIGITS'(1) << idx_q) : '1;
    end

    // Registered display outputs, all off in reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            display <= SEG_BLANK;
            dp      <= 1'b1;
            digit   <= '1;
        end else begin
            display <= seg_d;
            dp      <= dp_d;
            digit   <= digit_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: randomized self-checking bench against a cycle-count reference model
module tb_seg_scan_display;
    logic        clk = 1'b0;
    logic        rst, load, mode, blank_lz, busy, overflow, dp;
    logic [13:0] value_in;
    logic [3:0]  dp_in, brightness, digit;
    logic [6:0]  display;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] GLY [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] DASH = 7'b0111111;

    int         cyc, conv_left, conv_val;
    int         sd [4];
    bit         m_ovf;
    logic [6:0] e_disp;
    logic       e_dp;
    logic [3:0] e_dig;
    logic [6:0] seen_seg [4];
    logic       seen_dp [4];

    always #5 clk = ~clk;

    seg_scan_display #(.DIGITS(4), .BIN_W(14), .SCAN_DIV_W(6), .PWM_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .load      (load),
        .mode      (mode),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .brightness(brightness),
        .busy      (busy),
        .overflow  (overflow),
        .display   (display),
        .dp        (dp),
        .digit     (digit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock: predict registered outputs from the pre-edge view, advance the model, compare
    task automatic tick();
        int idx, ph;
        bit lz;
        idx = (cyc / 64) % 4;
        ph  = (cyc % 64) / 4;
        lz  = blank_lz && idx > 0;
        for (int k = idx; k < 4; k++) if (sd[k] != 0) lz = 1'b0;
        if (!rst) begin
            e_disp = 7'h7F;
            e_dp   = 1'b1;
            e_dig  = 4'hF;
        end else begin
            e_disp = m_ovf ? DASH : lz ? 7'h7F : GLY[sd[idx]];
            e_dp   = m_ovf | ~dp_in[idx];
            e_dig  = (ph <= int'(brightness)) ? 4'(~(1 << idx)) : 4'hF;
        end
        @(posedge clk);
        if (!rst) begin
            cyc = 0;
            conv_left = 0;
            m_ovf = 1'b0;
            for (int k = 0; k < 4; k++) sd[k] = 0;
        end else begin
            cyc++;
            if (conv_left > 0) begin
                conv_left--;
                if (conv_left == 0) begin
                    m_ovf = conv_val >= 10000;
                    for (int k = 0; k < 4; k++) sd[k] = (conv_val / (10 ** k)) % 10;
                end
            end else if (load) begin
                if (mode) begin
                    conv_left = 14;
                    conv_val  = int'(value_in);
                end else begin
                    m_ovf = 1'b0;
                    for (int k = 0; k < 4; k++) sd[k] = (int'(value_in) >> (4 * k)) & 15;
                end
            end
        end
        @(negedge clk);
        check("display", display, e_disp);
        check("dp", dp, e_dp);
        check("digit", digit, e_dig);
        check("busy", busy, conv_left > 0);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic scan_collect();
        for (int k = 0; k < 4; k++) begin
            seen_seg[k] = 'x;
            seen_dp[k]  = 1'bx;
        end
        for (int i = 0; i < 256; i++) begin
            tick();
            for (int k = 0; k < 4; k++)
                if (digit == 4'(~(1 << k))) begin
                    seen_seg[k] = display;
                    seen_dp[k]  = dp;
                end
        end
    endtask

    task automatic load_val(input int v, input bit m);
        value_in = 14'(v);
        mode     = m;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        int n, gap;
        int bvals [4] = '{9999, 10000, 0, 16383};
        bit bovf [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        cyc = 0; conv_left = 0; conv_val = 0; m_ovf = 1'b0;
        for (int k = 0; k < 4; k++) sd[k] = 0;
        rst = 1'b0; load = 1'b0; mode = 1'b0; value_in = '0;
        dp_in = '0; blank_lz = 1'b0; brightness = 4'hF;
        @(negedge clk);
        tick();
        tick();
        check("rst_digit", digit, 4'hF);
        check("rst_display", display, 7'h7F);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;

        load_val(14'h2BEE, 1'b0);
        scan_collect();
        check("hex_d3", seen_seg[3], 7'b0100100);
        check("hex_d2", seen_seg[2], 7'b0000011);
        check("hex_d1", seen_seg[1], 7'b0000110);
        check("hex_d0", seen_seg[0], 7'b0000110);

        load_val(1234, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("dec_busy_len", n, 14);
        check("dec_ovf", overflow, 1'b0);
        scan_collect();
        check("dec_d3", seen_seg[3], 7'b1111001);
        check("dec_d2", seen_seg[2], 7'b0100100);
        check("dec_d1", seen_seg[1], 7'b0110000);
        check("dec_d0", seen_seg[0], 7'b0011001);

        load_val(12000, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        check("ovf_flag", overflow, 1'b1);
        scan_collect();
        for (int k = 0; k < 4; k++) begin
            check("ovf_seg", seen_seg[k], DASH);
            check("ovf_dp", seen_dp[k], 1'b1);
        end

        dp_in = 4'b0100;
        blank_lz = 1'b1;
        load_val(7, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        scan_collect();
        check("lz_d3", seen_seg[3], 7'h7F);
        check("lz_d2", seen_seg[2], 7'h7F);
        check("lz_d2_dp", seen_dp[2], 1'b0);
        check("lz_d1", seen_seg[1], 7'h7F);
        check("lz_d0", seen_seg[0], 7'b1111000);
        check("lz_d0_dp", seen_dp[0], 1'b1);

        brightness = 4'h0;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (digit != 4'hF) n++;
        end
        check("bright_min_on", n, 16);
        brightness = 4'hF;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (digit != 4'hF) n++;
        end
        check("bright_max_on", n, 256);

        dp_in = '0;
        blank_lz = 1'b0;
        for (int b = 0; b < 4; b++) begin
            load_val(bvals[b], 1'b1);
            for (int i = 0; i < 16; i++) tick();
            check("bound_ovf", overflow, bovf[b]);
        end
        load_val(16383, 1'b0);
        check("hex_ovf_clear", overflow, 1'b0);

        load_val(321, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        load_val(999, 1'b1);
        for (int i = 0; i < 12; i++) tick();
        scan_collect();
        check("drop_d2", seen_seg[2], 7'b0110000);
        check("drop_d0", seen_seg[0], 7'b1111001);

        load_val(4321, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b0;
        tick();
        check("abort_busy", busy, 1'b0);
        check("abort_digit", digit, 4'hF);
        check("abort_display", display, 7'h7F);
        rst = 1'b1;
        scan_collect();
        check("abort_shadow0", seen_seg[0], 7'b1000000);
        check("abort_shadow3", seen_seg[3], 7'b1000000);

        for (int r = 0; r < 40; r++) begin
            dp_in      = 4'($urandom);
            blank_lz   = 1'($urandom_range(0, 1));
            brightness = 4'($urandom);
            load_val(($urandom_range(0, 3) == 0) ? int'(14'($urandom)) : int'($urandom_range(0, 9999)),
                     1'($urandom_range(0, 1)));
            gap = int'($urandom_range(1, 80));
            for (int i = 0; i < gap; i++) begin
                load     = ($urandom_range(0, 15) == 0);
                value_in = 14'($urandom);
                mode     = 1'($urandom_range(0, 1));
                rst      = ($urandom_range(0, 199) != 0);
                tick();
            end
            load = 1'b0;
            rst  = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised successor to the board's 4-digit hex seven-segment scanner.
- Drives an N-digit common-anode multiplexed display from a binary value, shown as hex or as decimal.
- Decimal mode uses a sequential binary-to-BCD converter. The block also provides leading-zero blanking, per-digit decimal points, PWM brightness and overflow indication.
- Sits beside the game top level and shows speed, lap time or score on the board display.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- BIN_W, 14, width of the binary input value.
- SCAN_DIV_W, 16, scan-tick divider width; digit advances every 2^SCAN_DIV_W clocks (must be >= 5).
- PWM_W, 4, brightness resolution in bits.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-low reset: state clears on any clk edge with rst==0.
- value_in  in  BIN_W  binary value to display.
- load  in  1  one-cycle strobe; captures value_in and mode.
- mode  in  1  0 = hex, 1 = decimal.
- dp_in  in  DIGITS  decimal-point request per digit (bit0 = rightmost); 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros.
- brightness  in  PWM_W  duty level; 0 = minimum, all-ones = full.
- busy  out  1  conversion in progress; a load is ignored while high.
- overflow  out  1  last decimal value did not fit in DIGITS digits.
- display  out  7  segments, active-low; bit0 = a ... bit6 = g.
- dp  out  1  decimal point, active-low.
- digit  out  DIGITS  digit anodes, active-low one-hot.

Behaviour:
- Reset values:
  - display = all ones, dp = 1, digit = all ones.
  - busy = 0, overflow = 0.
  - shadow digit register = 0, scan index = 0, divider = 0.
- Load accept: a load is accepted in cycle T when load==1 and busy==0. A load while busy==1 is dropped; no queueing.
- Hex mode latency: shadow nibble i = value_in[4i+3:4i] at T+1. Bits beyond BIN_W are zero-filled. overflow clears at T+1.
- Decimal mode latency:
  - busy rises at T+1.
  - Double-dabble runs one bit per cycle for BIN_W cycles.
  - At T+BIN_W+1 the shadow register and overflow update atomically and busy falls in the same cycle.
  - overflow = 1 when value_in >= 10^DIGITS.
- Shadow register: display never shows a partial conversion; the old shadow stays visible until commit.
- Overflow display: while overflow==1 every digit shows a dash (g only lit) and dp is off.
- Scan divider: free-running SCAN_DIV_W-bit counter. On wrap (tick), the scan index goes idx -> (idx+1) mod DIGITS.
- Output registration: display, dp and digit are registered and update the cycle after the tick.
- Brightness PWM: phase = divider[SCAN_DIV_W-1 : SCAN_DIV_W-PWM_W]. The digit anode is driven only when phase <= brightness; otherwise digit = all ones.
- Leading-zero blanking: when blank_lz==1, a digit k > 0 is blanked (display all ones, anode still scanned) if digits k..DIGITS-1 are all zero. Digit 0 is never blanked. The dp of a blanked digit still follows dp_in.
- Glyphs: hex 0-F use the standard table (0 = 1000000 ... F = 0001110). In decimal mode BCD digits are always 0-9.
- Reset mid-conversion: aborts the conversion; busy = 0 and shadow = 0 on the next edge.
- Live inputs: mode, blank_lz, dp_in and brightness are sampled live every cycle, except that mode is latched at load for conversion purposes.

Optional Feature:
- Macro: SEG_BLINK_EN.
- Defined: adds input blink_mask [DIGITS-1:0]. Masked digits are blanked (segments and dp off) while blink phase = 1. The blink phase toggles every 2^(SCAN_DIV_W+6) clocks from a dedicated counter, reset to 0.
- Undefined: no port and no counter; behaviour is exactly as above.

Decomposition:
- Package seg_pkg:
  - glyph function hex_to_seg (4 -> 7 bits);
  - constants SEG_BLANK (7'h7F) and SEG_DASH (7'b0111111);
  - mode encodings MODE_HEX and MODE_DEC.
- Sub-module bin2bcd_seq, parametrised by BIN_W and DIGITS:
  - ports start, bin, busy, done (1-cycle pulse), bcd, ovf;
  - holds the shift/add-3 state machine IDLE -> SHIFT (BIN_W cycles) -> IDLE.
- Top holds the load control, shadow register, scan/PWM counters, blanking and output registers.

Test Plan:
Bench settings: DIGITS=4, BIN_W=14, SCAN_DIV_W=6.
1. Hex mode: load value_in=14'h2BEE, mode=0 -> at T+1 shadow = {2,B,E,E}. Over one full scan the observed display per digit is 2,b,E,E, with digit cycling 1110, 1101, 1011, 0111.
2. Decimal mode: load 1234, mode=1 -> busy high T+1..T+14, falls at T+15 with shadow = {1,2,3,4} and overflow = 0. Display is unchanged before T+15.
3. Overflow: load 12000 decimal -> overflow = 1 at T+15; all four digits show 0111111 and dp = 1.
4. Blanking and dp: load 7 decimal with blank_lz=1 and dp_in=4'b0100 -> digits 3 and 1 show 1111111, digit 2 shows 1111111 with dp = 0, digit 0 shows 1111000.
5. Brightness: brightness=0 -> the anode is active for only 1/16 of each slot (4 of 64 clocks). brightness=15 -> active for all 64 clocks.
6. Dropped load and reset mid-conversion: a second load at T+5 during busy is ignored and the result equals the first value. Asserting rst=0 at T+7 -> next edge gives busy = 0, shadow = 0, digit = 1111, display = 1111111.
